// File: rtl/calc_op_sequencer_if.sv
// Handshake and operand/result bundle for the shared calculator arithmetic unit.
// The key FSM drives the master side and the sequencer implements the slave side.
interface calc_op_sequencer_if #(
  parameter int W = 24
);
  logic         iSTART;
  logic [1:0]   iOP;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         oBUSY;
  logic         oDONE;
  logic [W-1:0] oRESULT;
  logic [W-1:0] oREMAIN;
  logic         oNEG;
  logic         oERR;

  modport master (
    output iSTART, iOP, iA, iB,
    input  oBUSY, oDONE, oRESULT, oREMAIN, oNEG, oERR
  );

  modport slave (
    input  iSTART, iOP, iA, iB,
    output oBUSY, oDONE, oRESULT, oREMAIN, oNEG, oERR
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Iterative add/sub/shift-add-mul/restoring-div unit with display range checking.
// Define CALC_SEQ_EARLY_TERM_EN to end multiplies once the remaining multiplier bits are zero.
module calc_op_sequencer #(
  parameter int W    = 24,
  parameter int MAXV = 999999,
  parameter int MAXN = 99999
) (
  input logic                iCLK,
  input logic                iRST,
  calc_op_sequencer_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [W:0]     MAXV_W1 = (W+1)'(MAXV);
  localparam logic [2*W-1:0] MAXV_2W = (2*W)'(MAXV);
  localparam logic [W-1:0]   MAXN_W  = W'(MAXN);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_CHECK, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           dz_q, dz_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   remain_q, remain_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;

  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   trial;
  logic [W:0]     sum;
  logic [W-1:0]   diff;
  logic [W-1:0]   mag;
  logic           last_iter;

  // Datapath helpers; shifted is the W+1-bit partial remainder of the divider.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    ge      = (shifted >= {1'b0, b_q});
    trial   = shifted[W-1:0] - b_q;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    mag     = b_q - a_q;
`ifdef CALC_SEQ_EARLY_TERM_EN
    last_iter = (op_q == OP_MUL) ? (b_q[W-1:1] == '0) : (cnt_q == CW'(W-1));
`else
    last_iter = (cnt_q == CW'(W-1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    dz_d     = dz_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    remain_d = remain_q;
    neg_d    = neg_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.iSTART) begin
          a_d     = bus.iA;
          b_d     = bus.iB;
          op_d    = bus.iOP;
          cnt_d   = '0;
          prod_d  = '0;
          mcand_d = {{W{1'b0}}, bus.iA};
          rem_d   = '0;
          quo_d   = bus.iA;
          dz_d    = (bus.iOP == OP_DIV) && (bus.iB == '0);
          if (bus.iOP == OP_ADD || bus.iOP == OP_SUB || dz_d)
            state_d = S_CHECK;
`ifdef CALC_SEQ_EARLY_TERM_EN
          else if (bus.iOP == OP_MUL && bus.iB == '0)
            state_d = S_CHECK;
`endif
          else
            state_d = S_ITER;
        end
      end

      S_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          // Multiplier consumed LSB first from b_q, multiplicand walks left.
          if (b_q[0])
            prod_d = prod_q + mcand_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end else begin
          // Dividend shifts out of quo_q MSB first while quotient bits shift in.
          rem_d = ge ? trial : shifted[W-1:0];
          quo_d = {quo_q[W-2:0], ge};
        end
        if (last_iter)
          state_d = S_CHECK;
      end

      S_CHECK: begin
        state_d  = S_DONE;
        result_d = '0;
        remain_d = '0;
        neg_d    = 1'b0;
        err_d    = 1'b0;
        case (op_q)
          OP_ADD: begin
            if (sum > MAXV_W1) err_d = 1'b1;
            else               result_d = sum[W-1:0];
          end
          OP_SUB: begin
            if (a_q >= b_q)
              result_d = diff;
            else if (mag > MAXN_W)
              err_d = 1'b1;
            else begin
              result_d = mag;
              neg_d    = 1'b1;
            end
          end
          OP_MUL: begin
            if (prod_q > MAXV_2W) err_d = 1'b1;
            else                  result_d = prod_q[W-1:0];
          end
          default: begin
            if (dz_q)
              err_d = 1'b1;
            else begin
              result_d = quo_q;
              remain_d = rem_q;
            end
          end
        endcase
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dz_q     <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      remain_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dz_q     <= dz_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      remain_q <= remain_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign bus.oBUSY   = (state_q != S_IDLE);
  assign bus.oDONE   = (state_q == S_DONE);
  assign bus.oRESULT = result_q;
  assign bus.oREMAIN = remain_q;
  assign bus.oNEG    = neg_q;
  assign bus.oERR    = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed cases, control cases and random ops
// checked against an arithmetic reference model; a monitor compares every oDONE.
module tb_calc_op_sequencer;

  localparam int W    = 24;
  localparam int MAXV = 999999;
  localparam int MAXN = 99999;

  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         neg;
    logic         err;
    int           lat;
    int           cap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [W-1:0] last_res = '0;
  logic [W-1:0] last_rem = '0;
  logic         last_neg = 1'b0;
  logic         last_err = 1'b0;

  calc_op_sequencer_if #(.W(W)) bus ();

  calc_op_sequencer #(.W(W), .MAXV(MAXV), .MAXN(MAXN)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned la, lb, r;
    la = 64'(a);
    lb = 64'(b);
    e.op = op; e.a = a; e.b = b;
    e.res = '0; e.rem = '0; e.neg = 1'b0; e.err = 1'b0;
    e.lat = 2; e.cap = 0;
    case (op)
      OP_ADD: begin
        r = la + lb;
        if (r > 64'(MAXV)) e.err = 1'b1; else e.res = W'(r);
      end
      OP_SUB: begin
        if (la >= lb) e.res = W'(la - lb);
        else if (lb - la > 64'(MAXN)) e.err = 1'b1;
        else begin e.res = W'(lb - la); e.neg = 1'b1; end
      end
      OP_MUL: begin
        r = la * lb;
        if (r > 64'(MAXV)) e.err = 1'b1; else e.res = W'(r);
`ifdef CALC_SEQ_EARLY_TERM_EN
        e.lat = 2;
        for (int i = 0; i < W; i++) if (b[i]) e.lat = 3 + i;
`else
        e.lat = W + 2;
`endif
      end
      default: begin
        if (lb == 0) e.err = 1'b1;
        else begin e.res = W'(la / lb); e.rem = W'(la % lb); e.lat = W + 2; end
      end
    endcase
    return e;
  endfunction

  // Monitor: every oDONE pops one expectation.
  always @(negedge clk) begin
    if (!rst && bus.oDONE) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got oDONE=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        txn++;
        $display("txn %0d op=%0d a=%0d b=%0d -> res=%0d rem=%0d neg=%0b err=%0b lat=%0d",
                 txn, mon_e.op, mon_e.a, mon_e.b, bus.oRESULT, bus.oREMAIN, bus.oNEG, bus.oERR,
                 cyc - mon_e.cap + 1);
        chk("result",  bus.oRESULT, mon_e.res);
        chk("remain",  bus.oREMAIN, mon_e.rem);
        chk("neg",     bus.oNEG,    mon_e.neg);
        chk("err",     bus.oERR,    mon_e.err);
        chk("latency", 64'(cyc - mon_e.cap + 1), 64'(mon_e.lat));
        last_res = mon_e.res;
        last_rem = mon_e.rem;
        last_neg = mon_e.neg;
        last_err = mon_e.err;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int guard;
    guard = 0;
    while (bus.oBUSY && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk({nm, "_idle_timeout"}, 64'(guard), 64'(0));
  endtask

  // noise: 0 none, 1 add 1+1 then random starts, 2 random starts while busy.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int noise);
    exp_t e;
    int   guard;
    bit   first;
    wait_idle("pre");
    chk("hold_result", bus.oRESULT, last_res);
    chk("hold_remain", bus.oREMAIN, last_rem);
    chk("hold_neg",    bus.oNEG,    last_neg);
    chk("hold_err",    bus.oERR,    last_err);
    e = model(op, a, b);
    e.cap = cyc + 1;
    sb_q.push_back(e);
    bus.iSTART = 1'b1;
    bus.iOP    = op;
    bus.iA     = a;
    bus.iB     = b;
    @(negedge clk);
    bus.iSTART = 1'b0;
    bus.iA     = W'($urandom);
    bus.iB     = W'($urandom);
    bus.iOP    = 2'($urandom);
    chk("busy_after_start", bus.oBUSY, 1);
    guard = 0;
    first = 1'b1;
    while (bus.oBUSY && guard < 200) begin
      if (noise == 1 && first) begin
        bus.iSTART = 1'b1; bus.iOP = OP_ADD; bus.iA = 1; bus.iB = 1;
      end else if (noise != 0) begin
        bus.iSTART = 1'($urandom_range(0, 1));
        bus.iOP    = 2'($urandom);
        bus.iA     = W'($urandom);
        bus.iB     = W'($urandom);
      end
      first = 1'b0;
      @(negedge clk);
      guard++;
    end
    bus.iSTART = 1'b0;
    if (guard >= 200) chk("done_timeout", 64'(guard), 64'(0));
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_busy"},   bus.oBUSY,   0);
    chk({nm, "_done"},   bus.oDONE,   0);
    chk({nm, "_result"}, bus.oRESULT, 0);
    chk({nm, "_remain"}, bus.oREMAIN, 0);
    chk({nm, "_neg"},    bus.oNEG,    0);
    chk({nm, "_err"},    bus.oERR,    0);
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;
    bus.iSTART = 1'b0;
    bus.iOP    = '0;
    bus.iA     = '0;
    bus.iB     = '0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(OP_ADD, 123456, 876543, 0);
    run_op(OP_ADD, 500000, 500000, 0);
    run_op(OP_SUB, 12, 100011, 0);
    run_op(OP_SUB, 0, 100000, 0);
    run_op(OP_SUB, 50, 50, 0);
    run_op(OP_MUL, 999, 1001, 0);
    run_op(OP_MUL, 1000, 1000, 0);
    run_op(OP_MUL, 3, 5, 0);
    run_op(OP_DIV, 100, 7, 0);
    run_op(OP_DIV, 999999, 7, 0);
    run_op(OP_DIV, 7, 0, 0);
    run_op(OP_MUL, 999, 1001, 1);

    // Reset during ITER cycle 10 of a multiply: aborts with no oDONE.
    wait_idle("rst_test");
    bus.iSTART = 1'b1; bus.iOP = OP_MUL; bus.iA = 999; bus.iB = 1001;
    @(negedge clk);
    bus.iSTART = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_before_rst", bus.oBUSY, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_cleared("rst_iter");
    rst = 1'b0;
    last_res = '0; last_rem = '0; last_neg = 1'b0; last_err = 1'b0;
    repeat (W + 6) @(negedge clk);

    // Reset and start in the same cycle: reset wins.
    rst = 1'b1;
    bus.iSTART = 1'b1; bus.iOP = OP_ADD; bus.iA = 1; bus.iB = 1;
    @(negedge clk);
    rst = 1'b0;
    bus.iSTART = 1'b0;
    chk("rst_start_busy", bus.oBUSY, 0);
    @(negedge clk);
    chk("rst_start_busy2", bus.oBUSY, 0);
    chk("rst_start_done",  bus.oDONE, 0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case (op)
        OP_ADD: begin a = W'($urandom_range(0, 600000)); b = W'($urandom_range(0, 600000)); end
        OP_SUB: begin a = W'($urandom_range(0, 200000)); b = W'($urandom_range(0, 200000)); end
        OP_MUL: begin
          a = W'($urandom_range(0, 3000));
          case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom);
            default: b = W'($urandom_range(0, 1500));
          endcase
        end
        default: begin
          a = W'($urandom);
          case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom);
            default: b = W'($urandom_range(1, 5000));
          endcase
        end
      endcase
      run_op(op, a, b, ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    wait_idle("final");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Multi-cycle arithmetic sequencer for the PS/2 calculator. It replaces the combinational `+ - * / %` datapath in the calculator top level with one shared iterative unit. The unit runs a shift-add multiplier and a restoring divider, plus single-pass add and subtract. The top-level key FSM raises a start pulse on Enter, waits for done, then latches quotient/remainder, sign and error for the 7-segment display path.

## Interface
Parameters:
- `W`, 24: operand/result width in bits.
- `MAXV`, 999999: largest displayable positive result.
- `MAXN`, 99999: largest displayable negative magnitude (top digit shows '-').

Ports:
- `iCLK` in 1: single clock; every register is clocked on its rising edge.
- `iRST` in 1: reset, synchronous, active-high.
- `iSTART` in 1: start request; sampled only in IDLE.
- `iOP` in 2: operation select. 01 = add, 10 = sub, 11 = mul, 00 = div.
- `iA` in W: first operand, unsigned binary.
- `iB` in W: second operand, unsigned binary.
- `oBUSY` out 1: high in every state except IDLE.
- `oDONE` out 1: one-cycle pulse when the result registers are valid.
- `oRESULT` out W: sum, difference magnitude, product or quotient.
- `oREMAIN` out W: division remainder; 0 for the other operations.
- `oNEG` out 1: subtraction result is negative.
- `oERR` out 1: result out of range, or division by zero.

## Operation
States:
- IDLE: on `iSTART`, capture `iA`, `iB` and `iOP`, then go to the state below.
  - Add or sub: go to CHECK.
  - Div with `iB` = 0: set an internal zero-divide flag and go to CHECK.
  - Mul or div otherwise: clear the iteration counter and go to ITER.
- ITER, mul: shift-add into a 2W-bit accumulator, one multiplier bit per cycle, LSB first.
- ITER, div: restoring division, one quotient bit per cycle, MSB first, using a W+1-bit partial remainder.
- ITER exit: leave for CHECK after the W-th iteration (counter = W-1).
- CHECK: range-check the captured result and update the output registers, then go to DONE.
- DONE: assert `oDONE` for this cycle only, then go to IDLE.

Arithmetic rules applied in CHECK:
- Add: compute as a W+1-bit sum. If the sum > MAXV, flag an error.
- Sub, A ≥ B: RESULT = A−B, NEG = 0.
- Sub, A < B: magnitude = B−A. If magnitude > MAXN, flag an error; otherwise RESULT = magnitude, NEG = 1.
- Mul: if the full 2W-bit product > MAXV, flag an error.
- Div: RESULT = quotient, REMAIN = remainder. A zero divisor is an error.
- Error: RESULT = 0, REMAIN = 0, NEG = 0, ERR = 1.
- No error: ERR = 0.

Other behaviour:
- Output registers change only in CHECK or on reset. They hold between operations.
- `iSTART` outside IDLE is ignored. This includes the DONE cycle: no queuing, no effect on the op in flight.
- Operand inputs are don't-care after the capture cycle.
- `iOP` is decoded only at capture.

## Timing
- Reset: state = IDLE and counter = 0. All outputs are 0: `oBUSY`, `oDONE`, `oRESULT`, `oREMAIN`, `oNEG`, `oERR`.
- Reset in any state: aborts the operation, no `oDONE` is produced, and outputs clear on that edge.
- Reset and `iSTART` in the same cycle: reset wins.
- Capture edge is edge k. `oBUSY` is high from edge k onward.
- Add, sub and divide-by-zero: CHECK during cycle k..k+1, `oDONE` high during cycle k+1..k+2. Latency is 2 cycles.
- Mul and div: ITER runs for W cycles, then CHECK, then DONE. `oDONE` is high during cycle k+W+1..k+W+2. Latency is W+2 = 26 cycles.
- `oRESULT`, `oREMAIN`, `oNEG` and `oERR` are valid in the same cycle as `oDONE` and stay stable afterwards.
- `oBUSY` falls at the edge that ends DONE. A new `iSTART` in the following cycle is accepted.
- Back-to-back throughput: add/sub every 3 cycles, mul/div every W+3 cycles.

## Configuration
- `CALC_SEQ_EARLY_TERM_EN` defined: mul ITER exits to CHECK once the remaining shifted multiplier bits are all zero.
  - Latency becomes 2 + (index of the highest set bit of B) + 1.
  - B = 0 gives latency 2.
  - Div is unaffected.
- `CALC_SEQ_EARLY_TERM_EN` undefined: mul always takes W iterations.
- Results are identical either way; only the latency of `oDONE`/`oBUSY` changes.

## Test plan
- Add:
  - 123456 + 876543 → `oDONE` 2 cycles after start, RESULT = 999999, ERR = 0.
  - 500000 + 500000 → ERR = 1, RESULT = 0.
- Sub:
  - 12 − 100011 → NEG = 1, RESULT = 99999.
  - 0 − 100000 → ERR = 1, NEG = 0.
  - 50 − 50 → RESULT = 0, NEG = 0.
- Mul:
  - 999 × 1001 → RESULT = 999999, `oDONE` at 26 cycles (macro undefined).
  - 1000 × 1000 → ERR = 1.
  - With the macro defined, 3 × 5 → RESULT = 15 at latency 5.
- Div:
  - 100 / 7 → RESULT = 14, REMAIN = 2 at 26 cycles.
  - 999999 / 7 → RESULT = 142857, REMAIN = 0.
  - 7 / 0 → ERR = 1 at 2 cycles.
- Control:
  - Second `iSTART` (add 1 + 1) during an ongoing mul → ignored; the mul result is unchanged and there is exactly one `oDONE`.
  - `iRST` asserted in ITER cycle 10 → IDLE on the next edge, no `oDONE`, all outputs 0.
